// File: rtl/capi_cmd_pkg.sv
// capi_cmd_pkg: shared widths, PSL command/response codes, odd-parity helper and arbiter FSM states
package capi_cmd_pkg;

    localparam int TAG_W     = 8;
    localparam int COM_W     = 13;
    localparam int EA_W      = 64;
    localparam int SIZE_W    = 12;
    localparam int CCH_W     = 16;
    localparam int RSP_W     = 8;
    localparam int CRED_W    = 9;
    localparam int REQ_IDX_W = 3;

    localparam logic [COM_W-1:0] CMD_READ_CL_NA = 13'h0A00;
    localparam logic [COM_W-1:0] CMD_WRITE_NA   = 13'h0D00;
    localparam logic [RSP_W-1:0] RSP_DONE       = 8'h00;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic              tagpar;
        logic [COM_W-1:0]  com;
        logic              compar;
        logic [EA_W-1:0]   ea;
        logic              eapar;
        logic [CCH_W-1:0]  cch;
        logic [SIZE_W-1:0] size;
    } cmd_t;

    typedef struct packed {
        logic                 valid;
        logic [REQ_IDX_W-1:0] req;
        logic [TAG_W-1:0]     tag;
        logic [RSP_W-1:0]     response;
    } done_t;

    // Parity bit that makes the total number of ones (field + bit) odd; narrower fields zero-extend.
    function automatic logic odd_par(input logic [63:0] v);
        return ~^v;
    endfunction

    function automatic logic is_known_cmd(input logic [COM_W-1:0] com);
        return (com == CMD_READ_CL_NA) || (com == CMD_WRITE_NA);
    endfunction

    function automatic logic is_done_rsp(input logic [RSP_W-1:0] rsp);
        return rsp == RSP_DONE;
    endfunction

endpackage

// File: rtl/capi_cmd_arbiter_tag_pool.sv
// capi_tag_pool: free-tag bitmap with lowest-free encoder and per-tag owner table
module capi_tag_pool
    import capi_cmd_pkg::*;
#(
    parameter int MAX_TAGS = 16,
    parameter int TW       = $clog2(MAX_TAGS)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 alloc,
    input  logic [REQ_IDX_W-1:0] alloc_owner,
    input  logic                 release_en,
    input  logic [TW-1:0]        release_tag,
    output logic                 has_free,
    output logic [TW-1:0]        free_tag,
    output logic [MAX_TAGS-1:0]  busy,
    output logic [REQ_IDX_W-1:0] release_owner,
    output logic                 any_busy
);

    logic [MAX_TAGS-1:0]  busy_q, busy_d;
    logic [REQ_IDX_W-1:0] owner_q [MAX_TAGS];
    logic [REQ_IDX_W-1:0] owner_d [MAX_TAGS];

    // Lowest-index free tag; scanning downward lets the lowest hit win.
    always_comb begin
        has_free = 1'b0;
        free_tag = '0;
        for (int i = MAX_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                has_free = 1'b1;
                free_tag = TW'(i);
            end
        end
    end

    // A released tag only reaches the free bitmap next cycle, so alloc can never pick it this cycle.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        if (release_en) busy_d[release_tag] = 1'b0;
        if (alloc) begin
            busy_d[free_tag]  = 1'b1;
            owner_d[free_tag] = alloc_owner;
        end
    end

    // Pool state register; reset discards every outstanding tag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q  <= '0;
            owner_q <= '{default: '0};
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    assign busy          = busy_q;
    assign release_owner = owner_q[release_tag];
    assign any_busy      = |busy_q;

endmodule

// File: rtl/capi_cmd_arbiter.sv
// capi_cmd_arbiter: round-robin PSL command arbiter with tag pool, credit tracking and response routing.
// Optional macro CAPI_CMD_PARITY_EN: generate odd command parity and check rsp_tagpar.
module capi_cmd_arbiter
    import capi_cmd_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_TAGS = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [7:0]                 croom,
    input  logic [CCH_W-1:0]           ctx_handle,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*COM_W-1:0]   req_com,
    input  logic [NUM_REQ*EA_W-1:0]    req_ea,
    input  logic [NUM_REQ*SIZE_W-1:0]  req_size,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [TAG_W-1:0]           req_tag,
    output logic                       cmd_valid,
    output logic [TAG_W-1:0]           cmd_tag,
    output logic                       cmd_tagpar,
    output logic [COM_W-1:0]           cmd_com,
    output logic                       cmd_compar,
    output logic [2:0]                 cmd_abt,
    output logic [EA_W-1:0]            cmd_ea,
    output logic                       cmd_eapar,
    output logic [CCH_W-1:0]           cmd_cch,
    output logic [SIZE_W-1:0]          cmd_size,
    input  logic                       rsp_valid,
    input  logic [TAG_W-1:0]           rsp_tag,
    input  logic                       rsp_tagpar,
    input  logic [RSP_W-1:0]           rsp_response,
    input  logic [CRED_W-1:0]          rsp_credits,
    output logic                       done_valid,
    output logic [REQ_IDX_W-1:0]       done_req,
    output logic [TAG_W-1:0]           done_tag,
    output logic [RSP_W-1:0]           done_response,
    output logic                       idle,
    output logic                       err
);

    localparam int TW = $clog2(MAX_TAGS);

    state_e               state_q, state_d;
    logic [CRED_W-1:0]    credits_q, credits_d;
    logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    cmd_t                 cmd_q, cmd_d;
    done_t                done_q, done_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   rot;
    logic [REQ_IDX_W-1:0] off, win_idx;
    logic [REQ_IDX_W:0]   win_sum;
    logic                 credit_pos, grant;
    logic [COM_W-1:0]     sel_com;
    logic [EA_W-1:0]      sel_ea;
    logic [SIZE_W-1:0]    sel_size;

    logic                 has_free, any_busy, rsp_hit, rsp_par_bad;
    logic [TW-1:0]        free_tag, rsp_idx;
    logic [MAX_TAGS-1:0]  busy;
    logic [REQ_IDX_W-1:0] rsp_owner;

    capi_tag_pool #(.MAX_TAGS(MAX_TAGS), .TW(TW)) u_tag_pool (
        .clock         (clock),
        .reset_n       (reset_n),
        .alloc         (grant),
        .alloc_owner   (win_idx),
        .release_en    (rsp_hit),
        .release_tag   (rsp_idx),
        .has_free      (has_free),
        .free_tag      (free_tag),
        .busy          (busy),
        .release_owner (rsp_owner),
        .any_busy      (any_busy)
    );

    // Round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest valid, then rotate back.
    always_comb begin
        rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = REQ_IDX_W'(i);
        end
        win_sum    = {1'b0, rr_ptr_q} + {1'b0, off};
        win_idx    = (win_sum >= (REQ_IDX_W+1)'(NUM_REQ)) ? REQ_IDX_W'(win_sum - (REQ_IDX_W+1)'(NUM_REQ))
                                                          : REQ_IDX_W'(win_sum);
        credit_pos = !credits_q[CRED_W-1] && (credits_q != '0);
        grant      = (state_q == ST_RUN) && credit_pos && has_free && (|req_valid);
    end

    // Payload mux for the winning requester.
    always_comb begin
        sel_com  = '0;
        sel_ea   = '0;
        sel_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == REQ_IDX_W'(i)) begin
                sel_com  = req_com[i*COM_W +: COM_W];
                sel_ea   = req_ea[i*EA_W +: EA_W];
                sel_size = req_size[i*SIZE_W +: SIZE_W];
            end
        end
    end

    // Response lookup: only an in-range, outstanding tag is routed and freed.
    always_comb begin
        rsp_idx = rsp_tag[TW-1:0];
        rsp_hit = rsp_valid && ({1'b0, rsp_tag} < (TAG_W+1)'(MAX_TAGS)) && busy[rsp_idx];
    end

`ifdef CAPI_CMD_PARITY_EN
    assign rsp_par_bad = rsp_valid && (rsp_tagpar != odd_par(64'(rsp_tag)));
`else
    logic unused_rsp_tagpar;
    assign unused_rsp_tagpar = rsp_tagpar;
    assign rsp_par_bad       = 1'b0;
`endif

    // Next state, credits, round-robin pointer and sticky error.
    always_comb begin
        state_d   = (state_q == ST_LOAD) ? ST_RUN : (flush ? ST_DRAIN : ST_RUN);
        credits_d = (state_q == ST_LOAD) ? {1'b0, croom}
                                         : credits_q - CRED_W'(grant) + (rsp_valid ? rsp_credits : '0);
        rr_ptr_d  = grant ? ((win_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1) : rr_ptr_q;
        err_d     = err_q || (rsp_valid && !rsp_hit) || rsp_par_bad;
    end

    // Command bus contents for the cycle after a handshake; all-zero otherwise.
    always_comb begin
        cmd_d = '0;
        if (grant) begin
            cmd_d.valid = 1'b1;
            cmd_d.tag   = TAG_W'(free_tag);
            cmd_d.com   = sel_com;
            cmd_d.ea    = sel_ea;
            cmd_d.size  = sel_size;
            cmd_d.cch   = ctx_handle;
`ifdef CAPI_CMD_PARITY_EN
            cmd_d.tagpar = odd_par(64'(free_tag));
            cmd_d.compar = odd_par(64'(sel_com));
            cmd_d.eapar  = odd_par(sel_ea);
`endif
        end
    end

    // Completion pulse for a routed response.
    always_comb begin
        done_d          = '0;
        done_d.valid    = rsp_hit;
        done_d.req      = rsp_hit ? rsp_owner : '0;
        done_d.tag      = rsp_hit ? rsp_tag : '0;
        done_d.response = rsp_hit ? rsp_response : '0;
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_LOAD;
            credits_q <= '0;
            rr_ptr_q  <= '0;
            cmd_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            rr_ptr_q  <= rr_ptr_d;
            cmd_q     <= cmd_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req_ready     = grant ? (NUM_REQ'(1) << win_idx) : '0;
    assign req_tag       = grant ? TAG_W'(free_tag) : '0;
    assign cmd_valid     = cmd_q.valid;
    assign cmd_tag       = cmd_q.tag;
    assign cmd_tagpar    = cmd_q.tagpar;
    assign cmd_com       = cmd_q.com;
    assign cmd_compar    = cmd_q.compar;
    assign cmd_abt       = 3'b000;
    assign cmd_ea        = cmd_q.ea;
    assign cmd_eapar     = cmd_q.eapar;
    assign cmd_cch       = cmd_q.cch;
    assign cmd_size      = cmd_q.size;
    assign done_valid    = done_q.valid;
    assign done_req      = done_q.req;
    assign done_tag      = done_q.tag;
    assign done_response = done_q.response;
    assign idle          = (state_q != ST_LOAD) && !any_busy;
    assign err           = err_q;

endmodule

// File: tb/tb_capi_cmd_arbiter.sv
// tb_capi_cmd_arbiter: directed self-checking bench for capi_cmd_arbiter
module tb_capi_cmd_arbiter;
    import capi_cmd_pkg::*;

    localparam int NR = 4;
    localparam int MT = 16;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        croom = '0;
    logic [15:0]       ctx_handle = '0;
    logic              flush = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*13-1:0]  req_com = '0;
    logic [NR*64-1:0]  req_ea = '0;
    logic [NR*12-1:0]  req_size = '0;
    logic [NR-1:0]     req_ready;
    logic [7:0]        req_tag;
    logic              cmd_valid, cmd_tagpar, cmd_compar, cmd_eapar;
    logic [7:0]        cmd_tag;
    logic [12:0]       cmd_com;
    logic [2:0]        cmd_abt;
    logic [63:0]       cmd_ea;
    logic [15:0]       cmd_cch;
    logic [11:0]       cmd_size;
    logic              rsp_valid = 1'b0;
    logic [7:0]        rsp_tag = '0;
    logic              rsp_tagpar = 1'b0;
    logic [7:0]        rsp_response = '0;
    logic [8:0]        rsp_credits = '0;
    logic              done_valid;
    logic [2:0]        done_req;
    logic [7:0]        done_tag, done_response;
    logic              idle, err;

    logic [12:0] com_tab [NR];
    logic [63:0] ea_tab [NR];
    logic [11:0] size_tab [NR];

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    capi_cmd_arbiter #(.NUM_REQ(NR), .MAX_TAGS(MT)) dut (
        .clock(clock), .reset_n(reset_n), .croom(croom), .ctx_handle(ctx_handle), .flush(flush),
        .req_valid(req_valid), .req_com(req_com), .req_ea(req_ea), .req_size(req_size),
        .req_ready(req_ready), .req_tag(req_tag),
        .cmd_valid(cmd_valid), .cmd_tag(cmd_tag), .cmd_tagpar(cmd_tagpar), .cmd_com(cmd_com),
        .cmd_compar(cmd_compar), .cmd_abt(cmd_abt), .cmd_ea(cmd_ea), .cmd_eapar(cmd_eapar),
        .cmd_cch(cmd_cch), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_tagpar(rsp_tagpar),
        .rsp_response(rsp_response), .rsp_credits(rsp_credits),
        .done_valid(done_valid), .done_req(done_req), .done_tag(done_tag),
        .done_response(done_response), .idle(idle), .err(err)
    );

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic exp_par(input logic [63:0] v);
`ifdef CAPI_CMD_PARITY_EN
        return ~^v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic send_rsp(input logic [7:0] t, input logic [8:0] c, input logic [7:0] r, input logic bad);
        rsp_valid    = 1'b1;
        rsp_tag      = t;
        rsp_tagpar   = bad ? ^t : ~^t;
        rsp_credits  = c;
        rsp_response = r;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            com_tab[i]  = (i % 2 == 0) ? CMD_READ_CL_NA : CMD_WRITE_NA;
            ea_tab[i]   = 64'h0000_1000_0000_0000 | (64'(i) << 8);
            size_tab[i] = 12'd128 + 12'(i);
            req_com[i*13 +: 13] = com_tab[i];
            req_ea[i*64 +: 64]  = ea_tab[i];
            req_size[i*12 +: 12] = size_tab[i];
        end
        ctx_handle = 16'hBEEF;

        // Reset state, then credit exhaustion with a single requester
        croom = 8'd8;
        tick();
        tick();
        chk("rst_cmd_valid", 64'(cmd_valid), 0);
        chk("rst_done_valid", 64'(done_valid), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_ready", 64'(req_ready), 0);
        chk("rst_idle", 64'(idle), 0);
        chk("rst_abt", 64'(cmd_abt), 0);
        reset_n = 1'b1;
        tick();
        #1;
        chk("run_idle", 64'(idle), 1);
        req_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t1_ready", 64'(req_ready), 64'h1);
            chk("t1_req_tag", 64'(req_tag), 64'(k));
            tick();
            chk("t1_cmd_valid", 64'(cmd_valid), 1);
            chk("t1_cmd_tag", 64'(cmd_tag), 64'(k));
            chk("t1_cmd_com", 64'(cmd_com), 64'(CMD_READ_CL_NA));
            chk("t1_cmd_ea", cmd_ea, ea_tab[0]);
            chk("t1_cmd_size", 64'(cmd_size), 64'(size_tab[0]));
            chk("t1_cmd_cch", 64'(cmd_cch), 64'hBEEF);
            chk("t1_cmd_abt", 64'(cmd_abt), 0);
            chk("t1_cmd_tagpar", 64'(cmd_tagpar), 64'(exp_par(64'(k))));
        end
        #1;
        chk("t1_stall_ready", 64'(req_ready), 0);
        chk("t1_busy_idle", 64'(idle), 0);
        tick();
        chk("t1_cmd_pulse_end", 64'(cmd_valid), 0);
        send_rsp(8'd3, 9'd1, 8'h00, 1'b0);
        #1;
        chk("t1_rsp_cycle_ready", 64'(req_ready), 0);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t1_done_valid", 64'(done_valid), 1);
        chk("t1_done_tag", 64'(done_tag), 3);
        chk("t1_done_req", 64'(done_req), 0);
        chk("t1_resume_ready", 64'(req_ready), 64'h1);
        chk("t1_reuse_tag", 64'(req_tag), 3);
        tick();
        chk("t1_reuse_cmd_tag", 64'(cmd_tag), 3);
        chk("t1_done_pulse_end", 64'(done_valid), 0);
        chk("t1_restall", 64'(req_ready), 0);

        // Issue and response in the same cycle with one credit
        send_rsp(8'd0, 9'd1, 8'h00, 1'b0);
        tick();
        send_rsp(8'd1, 9'd1, 8'h05, 1'b0);
        #1;
        chk("t4_done_tag0", 64'(done_tag), 0);
        chk("t4_ready", 64'(req_ready), 64'h1);
        chk("t4_req_tag", 64'(req_tag), 0);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t4_no_stall", 64'(req_ready), 64'h1);
        chk("t4_req_tag1", 64'(req_tag), 1);
        chk("t4_cmd_tag", 64'(cmd_tag), 0);
        chk("t4_done_tag1", 64'(done_tag), 1);
        chk("t4_done_resp", 64'(done_response), 64'h05);
        req_valid = '0;
        tick();
        chk("t4_cmd_quiet", 64'(cmd_valid), 0);

        // Round robin across four requesters until the tag pool empties
        reset_n = 1'b0;
        croom = 8'd64;
        req_valid = 4'b1111;
        tick();
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("t2_ready", 64'(req_ready), 64'(1) << (k % 4));
            chk("t2_req_tag", 64'(req_tag), 64'(k));
            tick();
            chk("t2_cmd_valid", 64'(cmd_valid), 1);
            chk("t2_cmd_tag", 64'(cmd_tag), 64'(k));
            chk("t2_cmd_com", 64'(cmd_com), 64'(com_tab[k % 4]));
            chk("t2_cmd_ea", cmd_ea, ea_tab[k % 4]);
        end
        #1;
        chk("t2_tags_exhausted", 64'(req_ready), 0);
        send_rsp(8'd5, 9'd0, 8'h00, 1'b0);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t2_done_req", 64'(done_req), 1);
        chk("t2_done_tag", 64'(done_tag), 5);
        chk("t2_wrap_ready", 64'(req_ready), 64'h1);
        chk("t2_reuse_tag5", 64'(req_tag), 5);
        tick();
        req_valid = '0;
        chk("t2_cmd_tag5", 64'(cmd_tag), 5);

        // Response to a tag that is no longer outstanding
        send_rsp(8'd9, 9'd0, 8'h00, 1'b0);
        tick();
        rsp_valid = 1'b0;
        chk("t5_first_done", 64'(done_valid), 1);
        chk("t5_first_req", 64'(done_req), 1);
        chk("t5_first_err", 64'(err), 0);
        send_rsp(8'd9, 9'd0, 8'h00, 1'b0);
        tick();
        rsp_valid = 1'b0;
        chk("t5_stale_done", 64'(done_valid), 0);
        chk("t5_stale_err", 64'(err), 1);
        tick();
        chk("t5_err_sticky", 64'(err), 1);

        // Flush with three outstanding, then reset mid-traffic
        reset_n = 1'b0;
        croom = 8'd8;
        req_valid = 4'b0100;
        tick();
        chk("t6_rst_err", 64'(err), 0);
        chk("t6_rst_done", 64'(done_valid), 0);
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t6_ready", 64'(req_ready), 64'h4);
            chk("t6_req_tag", 64'(req_tag), 64'(k));
            tick();
        end
        flush = 1'b1;
        req_valid = '0;
        tick();
        req_valid = 4'b0100;
        #1;
        chk("t6_drain_ready", 64'(req_ready), 0);
        chk("t6_drain_idle", 64'(idle), 0);
        send_rsp(8'd0, 9'd1, 8'h00, 1'b1);
        tick();
        send_rsp(8'd1, 9'd1, 8'h00, 1'b0);
        #1;
        chk("t6_done0_valid", 64'(done_valid), 1);
        chk("t6_done0_tag", 64'(done_tag), 0);
`ifdef CAPI_CMD_PARITY_EN
        chk("t6_par_err", 64'(err), 1);
`else
        chk("t6_par_ignored", 64'(err), 0);
`endif
        tick();
        send_rsp(8'd2, 9'd1, 8'h00, 1'b0);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t6_done2_tag", 64'(done_tag), 2);
        chk("t6_done2_req", 64'(done_req), 2);
        chk("t6_drained_idle", 64'(idle), 1);
        chk("t6_drained_ready", 64'(req_ready), 0);
        flush = 1'b0;
        tick();
        #1;
        chk("t6_rerun_ready", 64'(req_ready), 64'h4);
        chk("t6_rerun_tag", 64'(req_tag), 0);
        tick();
        chk("t6_rerun_cmd", 64'(cmd_valid), 1);
        reset_n = 1'b0;
        croom = 8'd2;
        tick();
        chk("t7_rst_cmd", 64'(cmd_valid), 0);
        chk("t7_rst_ready", 64'(req_ready), 0);
        chk("t7_rst_idle", 64'(idle), 0);
        chk("t7_rst_err", 64'(err), 0);
        reset_n = 1'b1;
        tick();
        #1;
        chk("t7_ready0", 64'(req_ready), 64'h4);
        chk("t7_tag0_freed", 64'(req_tag), 0);
        tick();
        #1;
        chk("t7_tag1", 64'(req_tag), 1);
        tick();
        #1;
        chk("t7_croom_reload_stall", 64'(req_ready), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
